// File: rtl/psum_buff_pkg.sv
// -----------------------------------------------------------------------------
// psum_buff_pkg
// Shared constants and types for the partial-sum accumulation buffer.
//   DATA_WIDTH : default width of PE inputs, stored sums and output (25)
//   ADDR_WIDTH : default pointer width (3)
//   DEPTH      : default number of buffer entries, 2**ADDR_WIDTH (8)
//   GUARD_BITS : extra headroom bits on the internal 5-operand sum (3)
//   psum_t     : signed partial-sum type at the default data width
// -----------------------------------------------------------------------------
package psum_buff_pkg;

    localparam int DATA_WIDTH = 25;
    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 8;

    // Five signed operands of width W need at most W+3 bits to sum exactly.
    localparam int GUARD_BITS = 3;

    typedef logic signed [DATA_WIDTH-1:0] psum_t;

endpackage

// File: rtl/psum_adder.sv
// -----------------------------------------------------------------------------
// psum_adder
// Combinational 5-operand signed adder: head + pe0 + pe1 + pe2 + pe3.
// Optional feature macro: PSUM_BUFF_SAT_EN
//   defined   : result saturates to [-2^(data_width-1), 2^(data_width-1)-1]
//   undefined : result wraps (two's-complement truncation) to data_width bits
// Ports:
//   head      in  data_width signed : oldest stored partial sum
//   pe0..pe3  in  data_width signed : PE partial sums
//   sum       out data_width signed : accumulated result
// -----------------------------------------------------------------------------
module psum_adder
    import psum_buff_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
) (
    input  logic signed [data_width-1:0] head,
    input  logic signed [data_width-1:0] pe0_data,
    input  logic signed [data_width-1:0] pe1_data,
    input  logic signed [data_width-1:0] pe2_data,
    input  logic signed [data_width-1:0] pe3_data,
    output logic signed [data_width-1:0] sum
);

`ifdef PSUM_BUFF_SAT_EN
    // Full-precision sum so overflow can be detected and clamped.
    localparam int SW = data_width + GUARD_BITS;
`else
    // Wrapping result: the low data_width bits of a modular sum are the same
    // whether or not the guard bits are carried, so they are dropped here.
    localparam int SW = data_width;
`endif

    logic signed [SW-1:0] head_x;
    logic signed [SW-1:0] pe0_x;
    logic signed [SW-1:0] pe1_x;
    logic signed [SW-1:0] pe2_x;
    logic signed [SW-1:0] pe3_x;
    logic signed [SW-1:0] sum_wide;

    always_comb begin
        head_x   = SW'(head);
        pe0_x    = SW'(pe0_data);
        pe1_x    = SW'(pe1_data);
        pe2_x    = SW'(pe2_data);
        pe3_x    = SW'(pe3_data);
        sum_wide = head_x + pe0_x + pe1_x + pe2_x + pe3_x;
`ifdef PSUM_BUFF_SAT_EN
        // In range exactly when every bit above the result's sign bit
        // matches that sign bit.
        if ((sum_wide[SW-1:data_width-1] == '0) ||
            (sum_wide[SW-1:data_width-1] == '1)) begin
            sum = sum_wide[data_width-1:0];
        end else if (sum_wide[SW-1]) begin
            sum = {1'b1, {(data_width-1){1'b0}}};
        end else begin
            sum = {1'b0, {(data_width-1){1'b1}}};
        end
`else
        sum = sum_wide;
`endif
    end

endmodule

// File: rtl/psum_buff.sv
// -----------------------------------------------------------------------------
// psum_buff
// Partial-sum accumulation buffer: a circular FIFO of `depth` signed sums.
// Accumulate pops the head, adds four PE outputs and pushes the result at the
// tail; drain pops a finished sum and pushes a zero; init pushes a zero.
// Optional feature macro: PSUM_BUFF_SAT_EN (saturating accumulate, see
// psum_adder); default build wraps.
// Ports:
//   clk             in  1          : clock, rising edge
//   rst             in  1          : synchronous active-high reset
//   p_init          in  1          : push a zero at the tail
//   p_write_zero    in  1          : drain head, push a zero at the tail
//   p_valid_data    in  1          : accumulate head with PE data
//   pe0..pe3_data   in  data_width : signed PE partial sums
//   fifo_out        out data_width : head entry, 0 when empty
//   valid_fifo_out  out 1          : fifo_out is a finished sum drained now
// Command protocol: there is no back-pressure. A command is a one-cycle
// strobe that is always accepted at the next rising edge, priority
// p_init > p_write_zero > p_valid_data; an inapplicable command (init when
// full, drain/accumulate when empty) is dropped. valid_fifo_out qualifies
// fifo_out in the same cycle; the consumer takes it at that rising edge.
// depth must equal 2**addr_width so pointers wrap naturally.
// -----------------------------------------------------------------------------
module psum_buff
    import psum_buff_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int addr_width = ADDR_WIDTH,
    parameter int depth      = DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         p_init,
    input  logic                         p_write_zero,
    input  logic                         p_valid_data,
    input  logic signed [data_width-1:0] pe0_data,
    input  logic signed [data_width-1:0] pe1_data,
    input  logic signed [data_width-1:0] pe2_data,
    input  logic signed [data_width-1:0] pe3_data,
    output logic signed [data_width-1:0] fifo_out,
    output logic                         valid_fifo_out
);

    localparam logic [addr_width:0]   CNT_FULL = (addr_width+1)'(depth);
    localparam logic [addr_width:0]   CNT_ONE  = (addr_width+1)'(1);
    localparam logic [addr_width-1:0] PTR_ONE  = addr_width'(1);

    logic signed [data_width-1:0] mem_q [depth];
    logic signed [data_width-1:0] mem_d [depth];
    logic [addr_width-1:0]        rd_ptr_q, rd_ptr_d;
    logic [addr_width-1:0]        wr_ptr_q, wr_ptr_d;
    logic [addr_width:0]          count_q, count_d;
    logic signed [data_width-1:0] head;
    logic signed [data_width-1:0] acc_sum;
    logic                         empty;

    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    psum_adder #(
        .data_width (data_width)
    ) u_adder (
        .head     (head),
        .pe0_data (pe0_data),
        .pe1_data (pe1_data),
        .pe2_data (pe2_data),
        .pe3_data (pe3_data),
        .sum      (acc_sum)
    );

    // When full, rd_ptr == wr_ptr: acc_sum is formed from the old mem_q value
    // and only lands in mem_q at the edge, so the slot is read before written.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (p_init) begin
            if (count_q < CNT_FULL) begin
                mem_d[wr_ptr_q] = '0;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
                count_d         = count_q + CNT_ONE;
            end
        end else if (p_write_zero) begin
            if (!empty) begin
                mem_d[wr_ptr_q] = '0;
                rd_ptr_d        = rd_ptr_q + PTR_ONE;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
        end else if (p_valid_data) begin
            if (!empty) begin
                mem_d[wr_ptr_q] = acc_sum;
                rd_ptr_d        = rd_ptr_q + PTR_ONE;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign fifo_out       = empty ? '0 : head;
    assign valid_fifo_out = p_write_zero & ~p_init & ~empty;

endmodule

// File: tb/tb_psum_buff.sv
// -----------------------------------------------------------------------------
// tb_psum_buff
// Directed bench for psum_buff. Each step drives one cycle of inputs on the
// falling edge, checks fifo_out / valid_fifo_out 1 ns later (state from the
// previous rising edge plus combinational valid), and the command executes at
// the following rising edge. Overflow expectation follows PSUM_BUFF_SAT_EN.
// -----------------------------------------------------------------------------
module tb_psum_buff;
    import psum_buff_pkg::*;

    localparam psum_t MAX_P = 25'sh0FFFFFF;
    localparam psum_t MIN_N = 25'sh1000000;
`ifdef PSUM_BUFF_SAT_EN
    localparam psum_t OVF_EXP = MAX_P;
`else
    localparam psum_t OVF_EXP = MIN_N;
`endif

    // ---------------- clock / reset ----------------
    logic  clk = 1'b0;
    logic  rst;
    logic  p_init, p_write_zero, p_valid_data;
    psum_t pe0_data, pe1_data, pe2_data, pe3_data;
    psum_t fifo_out;
    logic  valid_fifo_out;

    always #5 clk = ~clk;

    psum_buff dut (
        .clk            (clk),
        .rst            (rst),
        .p_init         (p_init),
        .p_write_zero   (p_write_zero),
        .p_valid_data   (p_valid_data),
        .pe0_data       (pe0_data),
        .pe1_data       (pe1_data),
        .pe2_data       (pe2_data),
        .pe3_data       (pe3_data),
        .fifo_out       (fifo_out),
        .valid_fifo_out (valid_fifo_out)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic  rst;
        logic  init;
        logic  wz;
        logic  vd;
        psum_t pe0;
        psum_t pe1;
        psum_t pe2;
        psum_t pe3;
        psum_t exp_out;
        logic  exp_valid;
        string name;
    } vec_t;

    vec_t  vec_q [$];
    psum_t exp_q [$];
    int    total = 0;
    int    bad   = 0;

    function automatic void add(input logic r, input logic i, input logic w,
                                input logic v, input int a, input int b,
                                input int c, input int d, input int eo,
                                input logic ev, input string nm);
        vec_t t;
        t.rst = r; t.init = i; t.wz = w; t.vd = v;
        t.pe0 = psum_t'(a); t.pe1 = psum_t'(b);
        t.pe2 = psum_t'(c); t.pe3 = psum_t'(d);
        t.exp_out = psum_t'(eo); t.exp_valid = ev; t.name = nm;
        vec_q.push_back(t);
    endfunction

    // ---------------- driver + scoreboard ----------------
    task automatic step(input logic r, input logic i, input logic w,
                        input logic v, input psum_t a, input psum_t b,
                        input psum_t c, input psum_t d, input psum_t eo,
                        input logic ev, input string nm);
        @(negedge clk);
        rst = r; p_init = i; p_write_zero = w; p_valid_data = v;
        pe0_data = a; pe1_data = b; pe2_data = c; pe3_data = d;
        #1;
        total++;
        if (fifo_out !== eo) begin
            bad++;
            $display("FAIL %s fifo_out: got %0d expected %0d", nm, fifo_out, eo);
        end
        total++;
        if (valid_fifo_out !== ev) begin
            bad++;
            $display("FAIL %s valid_fifo_out: got %0b expected %0b", nm,
                     valid_fifo_out, ev);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; p_init = 1'b0; p_write_zero = 1'b0; p_valid_data = 1'b0;
        pe0_data = '0; pe1_data = '0; pe2_data = '0; pe3_data = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pass1 [8];
        rst = 1'b1; p_init = 1'b0; p_write_zero = 1'b0; p_valid_data = 1'b0;
        pe0_data = '0; pe1_data = '0; pe2_data = '0; pe3_data = '0;

        // Fill: 9 inits (the 9th lands on a full buffer and must be dropped),
        // then two accumulation passes over the 8 entries.
        for (int k = 0; k < 9; k++) add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "init");
        add(0, 0, 0, 1, 1, 1, 1, 2, 0, 0, "pass1");
        pass1[0] = 5;
        for (int k = 2; k <= 8; k++) begin
            add(0, 0, 0, 1, 1, k, 2, 2, 0, 0, "pass1");
            pass1[k-1] = 5 + k;
        end
        for (int k = 1; k <= 8; k++) begin
            add(0, 0, 0, 1, 1, k, 2, 2, pass1[k-1], 0, "pass2");
        end
        exp_q = '{11, 14, 16, 18, 20, 22, 24, 26};

        do_reset();
        foreach (vec_q[n]) begin
            step(vec_q[n].rst, vec_q[n].init, vec_q[n].wz, vec_q[n].vd,
                 vec_q[n].pe0, vec_q[n].pe1, vec_q[n].pe2, vec_q[n].pe3,
                 vec_q[n].exp_out, vec_q[n].exp_valid, vec_q[n].name);
        end

        // Drain finished sums, then confirm the refill left zeros everywhere.
        while (exp_q.size() > 0) begin
            step(0, 0, 1, 0, 0, 0, 0, 0, exp_q.pop_front(), 1, "drain");
        end
        for (int k = 0; k < 8; k++) step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "refill_zero");

        // Empty buffer: accumulate / drain ignored, then all three together.
        do_reset();
        step(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, "empty_vd");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "empty_wz");
        step(0, 1, 1, 1, 1, 2, 3, 4, 0, 0, "prio_all");
        step(0, 0, 0, 1, 1, 2, 3, 4, 0, 0, "one_acc");
        step(0, 0, 1, 1, 1, 1, 1, 1, 10, 1, "prio_wz_vd");
        step(0, 0, 0, 1, 1, 1, 1, 1, 0, 0, "acc_after_wz");
        step(0, 0, 1, 0, 0, 0, 0, 0, 4, 1, "drain_one");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "count_is_one");

        // Overflow at the positive limit.
        do_reset();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "ovf_init");
        step(0, 0, 0, 1, MAX_P, 0, 0, 0, 0, 0, "ovf_load");
        step(0, 0, 0, 1, 1, 0, 0, 0, MAX_P, 0, "ovf_add");
        step(0, 0, 1, 0, 0, 0, 0, 0, OVF_EXP, 1, "ovf_result");

        // Reset mid-stream with commands in the same cycle.
        do_reset();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "mid_init");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "mid_init");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "mid_init");
        step(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, "mid_acc");
        step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0, "mid_acc");
        step(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, "mid_acc");
        step(1, 1, 0, 1, 9, 9, 9, 9, 3, 0, "mid_rst");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "post_rst_empty");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst_init");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "post_rst_one");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
